keypad_scan_encoder: RTL



---
 rtl/keypad_scan_encoder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder
//   Walks the 12-key keypad mux select, debounces a pressed line and reports
//   one 4-bit key code per press over a valid/ready handshake.
//
// Ports
//   clk        in   system clock (rising edge)
//   rst_n      in   asynchronous active-low reset
//   scan_en    in   scanning enable (ignored while a key is held)
//   sel_out    out  [3:0] select code to the keypad mux (0..11)
//   key_in     in   mux output, 1 = selected key pressed
//   key_code   out  [3:0] reported key code
//   key_valid  out  key_code is valid
//   key_ready  in   consumer accepts the key
//   key_held   out  reported key is still down
//   overrun    out  sticky: a press was dropped while a report was pending
module keypad_scan_encoder #(
    parameter int SETTLE_CYCLES  = 2,
    parameter int DEBOUNCE_COUNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_en,
    output logic [3:0] sel_out,
    input  logic       key_in,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overrun
);

    localparam int DW = $clog2(SETTLE_CYCLES + 1);
    localparam int CW = $clog2(DEBOUNCE_COUNT + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_COUNT - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t        state_q, state_d;
    logic [3:0]    sel_q, sel_d, sel_next;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;
    logic          report;
    logic          hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN;
            sel_q   <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign sel_next = (sel_q == 4'd11) ? 4'd0 : sel_q + 4'd1;

    // Scan / debounce / hold sequencing. cnt_q counts consecutive 1 samples
    // in DEBOUNCE and consecutive 0 samples in HELD.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        report  = 1'b0;
        case (state_q)
            SCAN: begin
                if (scan_en) begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_d = '0;
                        if (key_in) begin
                            if (DEBOUNCE_COUNT == 1) begin
                                // a single sample is already enough to accept
                                report  = 1'b1;
                                state_d = HELD;
                                cnt_d   = '0;
                            end else begin
                                state_d = DEBOUNCE;
                                cnt_d   = CW'(1);
                            end
                        end else begin
                            sel_d = sel_next;
                        end
                    end else begin
                        dwell_d = dwell_q + DW'(1);
                    end
                end
            end
            DEBOUNCE: begin
                if (!scan_en) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end else if (!key_in) begin
                    state_d = SCAN;
                    sel_d   = sel_next;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    report  = 1'b1;
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                if (key_in) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = SCAN;
                    sel_d   = sel_next;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = SCAN;
                cnt_d   = '0;
                dwell_d = '0;
            end
        endcase
    end

    // Output handshake. A drop can never coincide with a handshake, so any
    // handshake clears overrun; a report on a handshake cycle simply reloads.
    always_comb begin
        hs      = valid_q && key_ready;
        code_d  = code_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (hs) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (report) begin
            if (!valid_q || hs) begin
                code_d  = sel_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign sel_out   = sel_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = (state_q == HELD);
    assign overrun   = ovr_q;

endmodule
